// File: rtl/axis_tlast_packetizer.sv
// AXI-Stream pass-through that frames an unframed stream with tlast,
// closing a packet on beat-count limit, idle timeout, or explicit flush.
module axis_tlast_packetizer #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned MAX_PKT_SIZE = 64,
   parameter int unsigned MAX_TIMEOUT  = 1024
) (
   input  logic                                 clk,
   input  logic                                 arstn,
   input  logic [$clog2(MAX_PKT_SIZE+1)-1:0]    cfg_pkt_size,
   input  logic [$clog2(MAX_TIMEOUT+1)-1:0]     cfg_timeout,
   input  logic                                 flush,
   input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   output logic [DATA_WIDTH-1:0]                m_axis_tdata,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic                                 m_axis_tlast,
   output logic                                 pkt_done,
   output logic                                 timeout_event
);

   localparam int unsigned SW = $clog2(MAX_PKT_SIZE+1);
   localparam int unsigned TW = $clog2(MAX_TIMEOUT+1);
   localparam logic [SW-1:0] SIZE_MAX = SW'(MAX_PKT_SIZE);
   localparam logic [TW-1:0] IDLE_SAT = '1;

   logic [DATA_WIDTH-1:0] h_data;
   logic                  h_valid;
   logic                  h_last;
   logic [SW-1:0]         beat_cnt;
   logic [SW-1:0]         size_q;
   logic [SW-1:0]         size_eff;
   logic [SW-1:0]         cnt_next;
   logic [TW-1:0]         idle_cnt;
   logic [TW-1:0]         tmo_q;
   logic                  o_free;
   logic                  accept;
   logic                  drain;
   logic                  hit_size;
   logic                  idle_run;
   logic                  tmo_hit;
   logic                  close_beat;

   assign o_free        = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = !h_valid || o_free;
   assign accept        = s_axis_tvalid && s_axis_tready;
   // A non-last beat is held back until its successor shows up, so a
   // later timeout/flush can still tag it as last.
   assign drain         = h_valid && o_free && (h_last || accept);
   assign pkt_done      = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // First beat of a packet sees the live config; later beats the latched one.
   always_comb begin
      size_eff = size_q;
      if (beat_cnt == '0) begin
         if (cfg_pkt_size == '0 || cfg_pkt_size > SIZE_MAX)
            size_eff = SIZE_MAX;
         else
            size_eff = cfg_pkt_size;
      end
   end

   assign cnt_next   = beat_cnt + SW'(1);
   assign hit_size   = (cnt_next == size_eff);
   assign idle_run   = h_valid && !h_last && !accept;
   assign tmo_hit    = idle_run && (tmo_q != '0) && (idle_cnt == tmo_q - TW'(1));
   assign close_beat = idle_run && (tmo_hit || flush);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         timeout_event <= 1'b0;
         h_data        <= '0;
         h_valid       <= 1'b0;
         h_last        <= 1'b0;
         beat_cnt      <= '0;
         idle_cnt      <= '0;
         size_q        <= '0;
         tmo_q         <= '0;
      end else begin
         timeout_event <= tmo_hit;

         if (drain) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= h_data;
            m_axis_tlast  <= h_last;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end

         if (accept) begin
            h_data   <= s_axis_tdata;
            h_valid  <= 1'b1;
            h_last   <= hit_size || flush;
            beat_cnt <= (hit_size || flush) ? '0 : cnt_next;
            if (beat_cnt == '0) begin
               size_q <= size_eff;
               tmo_q  <= cfg_timeout;
            end
         end else if (drain) begin
            h_valid <= 1'b0;
            h_last  <= 1'b0;
         end else if (close_beat) begin
            h_last   <= 1'b1;
            beat_cnt <= '0;
         end

         if (!idle_run || close_beat)
            idle_cnt <= '0;
         else if (idle_cnt != IDLE_SAT)
            idle_cnt <= idle_cnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_axis_tlast_packetizer.sv
// Bench for axis_tlast_packetizer: queue-based packet model checked every
// cycle, plus literal expectations on logged output per directed scenario.
module tb_axis_tlast_packetizer;

   localparam int DW   = 8;
   localparam int MAXP = 64;
   localparam int MAXT = 1024;
   localparam int SW   = $clog2(MAXP+1);
   localparam int TW   = $clog2(MAXT+1);

   logic          clk = 1'b0;
   logic          arstn = 1'b0;
   logic [SW-1:0] cfg_pkt_size;
   logic [TW-1:0] cfg_timeout;
   logic          flush;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          pkt_done;
   logic          timeout_event;

   axis_tlast_packetizer #(
      .DATA_WIDTH  (DW),
      .MAX_PKT_SIZE(MAXP),
      .MAX_TIMEOUT (MAXT)
   ) dut (
      .clk          (clk),
      .arstn        (arstn),
      .cfg_pkt_size (cfg_pkt_size),
      .cfg_timeout  (cfg_timeout),
      .flush        (flush),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .pkt_done     (pkt_done),
      .timeout_event(timeout_event)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   // model: beats accepted but not yet transferred, oldest first
   beat_t q[$];
   beat_t olog[$];
   int    ocyc[$];
   int    acyc[$];
   int    tevlog[$];
   int    pd_count = 0;

   int cnt, lsize, ltmo, idle;
   bit open_tail, exp_tev;
   bit prev_v, prev_r;
   logic [DW-1:0] prev_d;
   bit rand_mode = 0;

   function automatic int clampsz(input int v);
      return (v == 0 || v > MAXP) ? MAXP : v;
   endfunction

   always @(negedge clk) begin
      if (!arstn) begin
         q.delete();
         cnt = 0; lsize = 0; ltmo = 0; idle = 0;
         open_tail = 0; exp_tev = 0; prev_v = 0; prev_r = 0;
      end else begin
         beat_t e;
         bit    acc, hocc, lst;
         chk("timeout_event", timeout_event, exp_tev);
         if (timeout_event) tevlog.push_back(cyc);
         if (pkt_done) pd_count++;
         if (prev_v && !prev_r) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_data", m_axis_tdata, prev_d);
         end
         hocc = q.size() > (m_axis_tvalid ? 1 : 0);
         chk("s_tready", s_axis_tready, !(m_axis_tvalid && !m_axis_tready && hocc));
         if (m_axis_tvalid && m_axis_tready) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = q.pop_front();
               chk("out_data", m_axis_tdata, e.d);
               chk("out_last", m_axis_tlast, e.l);
               chk("pkt_done", pkt_done, e.l);
            end
            e.d = m_axis_tdata; e.l = m_axis_tlast;
            olog.push_back(e);
            ocyc.push_back(cyc);
         end else begin
            chk("pkt_done_idle", pkt_done, 0);
         end

         exp_tev = 0;
         acc = s_axis_tvalid && s_axis_tready;
         if (acc) begin
            if (cnt == 0) begin
               lsize = clampsz(int'(cfg_pkt_size));
               ltmo  = int'(cfg_timeout);
            end
            cnt++;
            lst = (cnt == lsize) || flush;
            if (lst) cnt = 0;
            e.d = s_axis_tdata; e.l = lst;
            q.push_back(e);
            open_tail = !lst;
            idle = 0;
            acyc.push_back(cyc);
         end else if (open_tail) begin
            idle++;
            if ((ltmo != 0 && idle == ltmo) || flush) begin
               exp_tev = (ltmo != 0 && idle == ltmo);
               q[q.size()-1].l = 1'b1;
               open_tail = 0;
               cnt = 0;
            end
         end
         prev_v = m_axis_tvalid;
         prev_r = m_axis_tready;
         prev_d = m_axis_tdata;
      end
   end

   always begin
      @(posedge clk); #1;
      if (rand_mode) m_axis_tready = 1'($urandom_range(0, 1));
   end

   task automatic clear_logs();
      olog.delete(); ocyc.delete(); acyc.delete(); tevlog.delete();
      pd_count = 0;
   endtask

   task automatic send(input int d);
      int  n = 0;
      logic ok;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(d);
      do begin
         @(negedge clk); ok = s_axis_tready;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 300);
      chk("send_accept", ok, 1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nl;
      flush = 0; s_axis_tvalid = 0; s_axis_tdata = '0; m_axis_tready = 1;
      cfg_pkt_size = 4; cfg_timeout = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_tev", timeout_event, 0);
      chk("rst_tready", s_axis_tready, 1);
      arstn = 1;
      idle_cycles(2);

      // size 4, continuous input, no bubbles
      clear_logs();
      for (int i = 0; i < 8; i++) send(i);
      idle_cycles(5);
      chk("t1_count", olog.size(), 8);
      for (int i = 0; i < olog.size(); i++) begin
         chk($sformatf("t1_data%0d", i), olog[i].d, i);
         chk($sformatf("t1_last%0d", i), olog[i].l, (i % 4 == 3));
         chk($sformatf("t1_cyc%0d", i), ocyc[i] - ocyc[0], i);
      end
      chk("t1_latency", ocyc[0] - acyc[0], 2);
      chk("t1_pkt_done", pd_count, 2);

      // timeout 5 after 3 beats
      cfg_pkt_size = 8; cfg_timeout = 5;
      clear_logs();
      send(10); send(11); send(12);
      idle_cycles(12);
      chk("t2_count", olog.size(), 3);
      chk("t2_last", {olog[0].l, olog[1].l, olog[2].l}, 3'b001);
      chk("t2_data2", olog[2].d, 12);
      chk("t2_tev_n", tevlog.size(), 1);
      chk("t2_tev_delay", tevlog[0] - acyc[2] - 1, 5);
      clear_logs();
      for (int i = 20; i < 28; i++) send(i);
      idle_cycles(5);
      chk("t2b_count", olog.size(), 8);
      nl = 0;
      foreach (olog[i]) nl += olog[i].l;
      chk("t2b_lasts", nl, 1);
      chk("t2b_last7", olog[7].l, 1);
      chk("t2b_tev_n", tevlog.size(), 0);

      // flush closes the pending beat
      cfg_timeout = 0;
      clear_logs();
      send(30); send(31);
      idle_cycles(2);
      pulse_flush();
      idle_cycles(5);
      chk("t3_count", olog.size(), 2);
      chk("t3_last", {olog[0].l, olog[1].l}, 2'b01);
      chk("t3_tev_n", tevlog.size(), 0);

      // size 1, then size 0 meaning 64
      cfg_pkt_size = 1;
      clear_logs();
      for (int i = 40; i < 44; i++) send(i);
      idle_cycles(4);
      chk("t4_count", olog.size(), 4);
      chk("t4_pkt_done", pd_count, 4);
      cfg_pkt_size = 0;
      clear_logs();
      for (int i = 0; i < 130; i++) send(i);
      idle_cycles(3);
      chk("t4b_count", olog.size(), 129);
      nl = 0;
      foreach (olog[i]) nl += olog[i].l;
      chk("t4b_lasts", nl, 2);
      chk("t4b_last63", olog[63].l, 1);
      chk("t4b_last127", olog[127].l, 1);
      pulse_flush();
      idle_cycles(3);
      chk("t4b_final", olog.size(), 130);
      chk("t4b_last129", olog[129].l, 1);

      // random backpressure, size 5
      cfg_pkt_size = 5;
      clear_logs();
      rand_mode = 1;
      for (int i = 0; i < 40; i++) send(i + 100);
      idle_cycles(20);
      rand_mode = 0;
      idle_cycles(1);
      m_axis_tready = 1;
      idle_cycles(5);
      chk("t5_count", olog.size(), 40);
      for (int i = 0; i < olog.size(); i++) begin
         chk($sformatf("t5_data%0d", i), olog[i].d, i + 100);
         chk($sformatf("t5_last%0d", i), olog[i].l, (i % 5 == 4));
      end
      chk("t5_pkt_done", pd_count, 8);

      // size change mid-packet takes effect next packet
      cfg_pkt_size = 4;
      clear_logs();
      send(0); send(1);
      cfg_pkt_size = 2;
      for (int i = 2; i < 8; i++) send(i);
      idle_cycles(5);
      chk("t6_count", olog.size(), 8);
      nl = 0;
      foreach (olog[i]) nl = nl | (int'(olog[i].l) << i);
      chk("t6_lastmask", nl, 32'hA8);

      // reset mid-packet with O stalled
      cfg_pkt_size = 4;
      m_axis_tready = 0;
      send(50); send(51);
      idle_cycles(1);
      chk("t7_pre_tvalid", m_axis_tvalid, 1);
      arstn = 0;
      #1;
      chk("t7_rst_tvalid", m_axis_tvalid, 0);
      chk("t7_rst_tready", s_axis_tready, 1);
      idle_cycles(2);
      arstn = 1;
      m_axis_tready = 1;
      clear_logs();
      for (int i = 60; i < 64; i++) send(i);
      idle_cycles(5);
      chk("t7_count", olog.size(), 4);
      for (int i = 0; i < olog.size(); i++) begin
         chk($sformatf("t7_data%0d", i), olog[i].d, i + 60);
         chk($sformatf("t7_last%0d", i), olog[i].l, (i == 3));
      end
      chk("model_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
